// File: rtl/pipe_regfile_pkg.sv
// Shared constants for the pipelined register file: $gp/$sp defaults and
// address-width derivation.
package pipe_regfile_pkg;

    localparam int          GP_IDX_DEF  = 28;
    localparam int          SP_IDX_DEF  = 29;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_regfile_sb.sv
// Pending-write scoreboard: one saturating counter per register, issue
// back-pressure and per-read-port busy flags. Honors PIPE_REGFILE_BYPASS_EN.
module pipe_regfile_sb
    import pipe_regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             wr_dec;
    logic             iss_inc;

    // Register 0 and out-of-range addresses never hold a pending write.
    function automatic logic valid_reg(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_REGS);
    endfunction

    assign wr_dec  = we && valid_reg(wa);
    assign iss_inc = iss_valid && iss_ready && valid_reg(iss_addr);

    always_comb begin
        iss_ready = 1'b1;
        if (valid_reg(iss_addr) && cnt[iss_addr] == CNT_MAX && !(wr_dec && wa == iss_addr))
            iss_ready = 1'b0;
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (valid_reg(rd_addr[k*ADDR_W +: ADDR_W])) begin
`ifdef PIPE_REGFILE_BYPASS_EN
                // A write retiring the last pending entry clears busy this cycle.
                rd_busy[k] = (cnt[rd_addr[k*ADDR_W +: ADDR_W]] != '0) &&
                             !(wr_dec && wa == rd_addr[k*ADDR_W +: ADDR_W] &&
                               cnt[rd_addr[k*ADDR_W +: ADDR_W]] == CNT_ONE);
`else
                rd_busy[k] = cnt[rd_addr[k*ADDR_W +: ADDR_W]] != '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (iss_inc && iss_addr == ADDR_W'(r) && !(wr_dec && wa == ADDR_W'(r)))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (wr_dec && wa == ADDR_W'(r) && !(iss_inc && iss_addr == ADDR_W'(r))
                         && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// Pipelined MIPS GRF: multi-port async reads, write-back port, pending-write
// scoreboard. Define PIPE_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter int                NUM_RD   = 2,
    parameter int                CNT_W    = 2,
    parameter int                GP_IDX   = GP_IDX_DEF,
    parameter logic [DATA_W-1:0] GP_INIT  = DATA_W'(GP_INIT_DEF),
    parameter int                SP_IDX   = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
    localparam int               ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [31:0]              wpc
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    function automatic logic valid_reg(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_REGS);
    endfunction

    assign wr_en = we && valid_reg(wa);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= (r == GP_IDX) ? GP_INIT : (r == SP_IDX) ? SP_INIT : '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
`ifndef SYNTHESIS
            $display("%d@%h: $%d <= %h", $time, wpc, wa, wd);
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (valid_reg(rd_addr[k*ADDR_W +: ADDR_W])) begin
                rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef PIPE_REGFILE_BYPASS_EN
                if (wr_en && wa == rd_addr[k*ADDR_W +: ADDR_W])
                    rd_data[k*DATA_W +: DATA_W] = wd;
`endif
            end
        end
    end

    pipe_regfile_sb #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .we        (we),
        .wa        (wa),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

endmodule
